// File: rtl/buff_uart_host_if.sv
// buff_uart_host_if
//   Bundles the signals of buff_uart_host apart from clock and reset.
//   It carries the two local valid/ready streams and the register bus
//   toward the buffered UART peripheral.
//   Modports:
//     master - the host: drives in_ready, the out_* stream, the bus
//              request signals and timeout_error
//     slave  - the environment: the stream producer and consumer plus the
//              peripheral, which drives bus_rdata, bus_ack and bus_retry
interface buff_uart_host_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDRESS_WIDTH-1:0] bus_address;
  logic                     bus_read_enable;
  logic                     bus_write_enable;
  logic [WIDTH-1:0]         bus_wdata;
  logic [WIDTH-1:0]         bus_rdata;
  logic                     bus_ack;
  logic                     bus_retry;
  logic                     timeout_error;

  modport master (
    input  in_data, in_valid, out_ready, bus_rdata, bus_ack, bus_retry,
    output in_ready, out_data, out_valid, bus_address, bus_read_enable,
           bus_write_enable, bus_wdata, timeout_error
  );

  modport slave (
    output in_data, in_valid, out_ready, bus_rdata, bus_ack, bus_retry,
    input  in_ready, out_data, out_valid, bus_address, bus_read_enable,
           bus_write_enable, bus_wdata, timeout_error
  );
endinterface

// File: rtl/buff_uart_host.sv
// buff_uart_host
//   System-side bus initiator for a buffered UART peripheral. It polls
//   RX_ADDRESS for received words and presents them on the out stream. It
//   writes words from the in stream to TX_ADDRESS. A retry response means
//   the RX buffer was empty or the TX buffer was full. A request with no ack
//   for TIMEOUT cycles is abandoned, and timeout_error pulses.
//   Ports:
//     clock  - system clock, rising edge
//     resetn - asynchronous active-low reset
//     port   - buff_uart_host_if.master: in/out streams and register bus
module buff_uart_host #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int RX_ADDRESS    = 1,
  parameter int TX_ADDRESS    = 2,
  parameter int POLL_INTERVAL = 4,
  parameter int TIMEOUT       = 15
) (
  input logic              clock,
  input logic              resetn,
  buff_uart_host_if.master port
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_INTERVAL + 1);

  typedef enum logic [1:0] {IDLE, READ_REQ, WRITE_REQ} state_t;
  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

  state_t             state, state_next;
  grant_t             last_grant, last_grant_next;
  logic [WAIT_W-1:0]  wait_count, wait_count_next;
  logic [POLL_W-1:0]  poll_count, poll_count_next;
  logic [WIDTH-1:0]   out_data_next, wdata_next;
  logic               out_valid_next, timeout_next;
  logic               read_eligible, write_eligible, grant_read, grant_write;
  logic               wait_expired;

  // A receive buffer that is still full blocks polling, so an unread word
  // is never overwritten.
  assign read_eligible  = (poll_count == '0) && !port.out_valid;
  assign write_eligible = port.in_valid;
  // When both are eligible, the candidate that lost last time wins.
  assign grant_read  = read_eligible && (!write_eligible || last_grant == GRANT_WRITE);
  assign grant_write = write_eligible && !grant_read;

  assign wait_expired = (wait_count == WAIT_W'(TIMEOUT - 1));

  // The word is consumed only by the ack cycle of a non-retried write.
  assign port.in_ready = (state == WRITE_REQ) && port.bus_ack && !port.bus_retry;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    state_next      = state;
    last_grant_next = last_grant;
    wait_count_next = wait_count;
    poll_count_next = poll_count;
    out_data_next   = port.out_data;
    out_valid_next  = port.out_valid && !port.out_ready;
    wdata_next      = port.bus_wdata;
    timeout_next    = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_read) begin
          state_next      = READ_REQ;
          last_grant_next = GRANT_READ;
          wait_count_next = '0;
        end else if (grant_write) begin
          state_next      = WRITE_REQ;
          last_grant_next = GRANT_WRITE;
          wait_count_next = '0;
          wdata_next      = port.in_data;
        end else if (poll_count != '0) begin
          poll_count_next = poll_count - 1'b1;
        end
      end
      READ_REQ: begin
        if (port.bus_ack) begin
          state_next = IDLE;
          if (port.bus_retry) begin
            poll_count_next = POLL_W'(POLL_INTERVAL);
          end else begin
            out_data_next   = port.bus_rdata;
            out_valid_next  = 1'b1;
            poll_count_next = '0;
          end
        end else if (wait_expired) begin
          state_next      = IDLE;
          timeout_next    = 1'b1;
          poll_count_next = POLL_W'(POLL_INTERVAL);
        end else begin
          wait_count_next = wait_count + 1'b1;
        end
      end
      WRITE_REQ: begin
        // A retried or timed-out word stays on in_data and is offered again.
        if (port.bus_ack || wait_expired) begin
          state_next   = IDLE;
          timeout_next = !port.bus_ack;
          wdata_next   = '0;
        end else begin
          wait_count_next = wait_count + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered copies of the next state, so a request
  // appears the cycle after the grant and drops the cycle after ack/timeout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state                 <= IDLE;
      last_grant            <= GRANT_READ;
      wait_count            <= '0;
      poll_count            <= '0;
      port.out_data         <= '0;
      port.out_valid        <= 1'b0;
      port.bus_address      <= '0;
      port.bus_read_enable  <= 1'b0;
      port.bus_write_enable <= 1'b0;
      port.bus_wdata        <= '0;
      port.timeout_error    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state                 <= state_next;
      last_grant            <= last_grant_next;
      wait_count            <= wait_count_next;
      poll_count            <= poll_count_next;
      port.out_data         <= out_data_next;
      port.out_valid        <= out_valid_next;
      port.bus_read_enable  <= (state_next == READ_REQ);
      port.bus_write_enable <= (state_next == WRITE_REQ);
      port.bus_address      <= (state_next == READ_REQ)  ? ADDRESS_WIDTH'(RX_ADDRESS) :
                               (state_next == WRITE_REQ) ? ADDRESS_WIDTH'(TX_ADDRESS) : '0;
      port.bus_wdata        <= wdata_next;
      port.timeout_error    <= timeout_next;
    end
  end
endmodule

// File: tb/tb_buff_uart_host.sv
// tb_buff_uart_host
//   Directed bench for buff_uart_host. The main thread plays the stream
//   producer, the stream consumer and the peripheral. Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_buff_uart_host;
  localparam int POLL_INTERVAL = 4;
  localparam int TIMEOUT       = 15;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  buff_uart_host_if #(.WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  buff_uart_host #(
    .WIDTH(8), .ADDRESS_WIDTH(4), .RX_ADDRESS(1), .TX_ADDRESS(2),
    .POLL_INTERVAL(POLL_INTERVAL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .port  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for a request, checks its kind, address and data, and then acks
  // it on request cycle ack_cycle. gap is the number of falling edges spent
  // waiting for the request to appear.
  task automatic access(input string tag, input bit exp_write, input int ack_cycle,
                        input bit retry, input logic [7:0] data, output int gap);
    int n = 0;
    while (!(bus.bus_read_enable || bus.bus_write_enable) && n < 40) begin
      @(negedge clock);
      n++;
    end
    gap = n;
    check({tag, " request seen"}, 32'(bus.bus_read_enable || bus.bus_write_enable), 1);
    check({tag, " kind"}, {bus.bus_write_enable, bus.bus_read_enable}, exp_write ? 2 : 1);
    check({tag, " address"}, bus.bus_address, exp_write ? 2 : 1);
    if (exp_write) check({tag, " wdata"}, bus.bus_wdata, data);
    for (int c = 1; c < ack_cycle; c++) begin
      if (exp_write) check({tag, " in_ready before ack"}, bus.in_ready, 0);
      @(negedge clock);
    end
    check({tag, " enable held"}, {bus.bus_write_enable, bus.bus_read_enable}, exp_write ? 2 : 1);
    bus.bus_ack   = 1'b1;
    bus.bus_retry = retry;
    if (!exp_write) bus.bus_rdata = data;
    #1;
    if (exp_write) check({tag, " in_ready on ack"}, bus.in_ready, !retry);
    @(negedge clock);
    bus.bus_ack   = 1'b0;
    bus.bus_retry = 1'b0;
    bus.bus_rdata = 8'h00;
    check({tag, " enables drop"}, {bus.bus_write_enable, bus.bus_read_enable}, 0);
    if (!exp_write) begin
      check({tag, " out_valid"}, bus.out_valid, !retry);
      if (!retry) check({tag, " out_data"}, bus.out_data, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap, cycles;
    bit ready_seen, early_error, idle_read;

    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.bus_rdata = 8'h00; bus.bus_ack = 1'b0; bus.bus_retry = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset enables", {bus.bus_write_enable, bus.bus_read_enable}, 0);
    check("reset address", bus.bus_address, 0);
    check("reset wdata", bus.bus_wdata, 0);
    check("reset out", {bus.out_valid, bus.out_data}, 0);
    check("reset in_ready/timeout", {bus.in_ready, bus.timeout_error}, 0);
    resetn = 1'b1;

    // Read with retry: the first poll sees an empty RX. The gap before the
    // next poll is POLL_INTERVAL countdown cycles plus the grant cycle.
    access("poll empty", 0, 1, 1, 8'hEE, gap);
    check("first poll gap", gap, 1);
    access("poll data", 0, 1, 0, 8'h3C, gap);
    check("repoll gap", gap, POLL_INTERVAL + 1);

    // Backpressure: out_valid holds, and no poll is issued while it is set.
    idle_read = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.bus_read_enable) idle_read = 1'b1;
    end
    check("no poll while full", idle_read, 0);
    check("out held", {bus.out_valid, bus.out_data}, {1'b1, 8'h3C});

    // Single write, ack on the second request cycle; writes proceed while full.
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    access("write A5", 1, 2, 0, 8'hA5, gap);
    check("write A5 gap", gap, 1);
    bus.in_valid = 1'b0;
    check("out still held", {bus.out_valid, bus.out_data}, {1'b1, 8'h3C});

    // Timeout of a write: it is never acked.
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    gap = 0;
    while (!bus.bus_write_enable && gap < 40) begin
      @(negedge clock);
      gap++;
    end
    cycles = 0; ready_seen = 1'b0; early_error = 1'b0;
    while (bus.bus_write_enable && cycles < 40) begin
      cycles++;
      #1;
      if (bus.in_ready) ready_seen = 1'b1;
      if (bus.timeout_error) early_error = 1'b1;
      @(negedge clock);
    end
    check("timeout request cycles", cycles, TIMEOUT);
    check("timeout no early pulse", early_error, 0);
    check("timeout in_ready never", ready_seen, 0);
    check("timeout pulse", bus.timeout_error, 1);
    @(negedge clock);
    check("timeout pulse width", bus.timeout_error, 0);
    // Reissued with the same word, then retried (TX full), then stored.
    access("write reissue", 1, 1, 1, 8'h5A, gap);
    check("reissue gap", gap, 0);
    access("write after retry", 1, 1, 0, 8'h5A, gap);
    check("retry reoffer gap", gap, 1);

    // Arbitration: writes and reads alternate once the consumer drains.
    bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      access($sformatf("arb write %0d", k), 1, 1, 0, 8'(k), gap);
      check($sformatf("arb write %0d gap", k), gap, 1);
      bus.in_data = 8'(k + 1);
      if (k == 4) bus.in_valid = 1'b0;
      if (k < 4) begin
        access($sformatf("arb read %0d", k), 0, 1, 0, 8'(8'hB0 + k), gap);
        check($sformatf("arb read %0d gap", k), gap, 1);
      end
    end

    // Reset during a read request.
    gap = 0;
    while (!bus.bus_read_enable && gap < 40) begin
      @(negedge clock);
      gap++;
    end
    check("read before reset", bus.bus_read_enable, 1);
    resetn = 1'b0;
    #1;
    check("async reset enables", {bus.bus_write_enable, bus.bus_read_enable}, 0);
    check("async reset address", bus.bus_address, 0);
    check("async reset out", {bus.out_valid, bus.out_data}, 0);
    check("async reset flags", {bus.in_ready, bus.timeout_error}, 0);
    repeat (2) @(negedge clock);
    // After release both candidates are eligible and last_grant is READ,
    // so the write wins the first arbitration.
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    resetn = 1'b1;
    access("post-reset write", 1, 1, 0, 8'h77, gap);
    check("post-reset gap", gap, 1);
    bus.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
